// File: rtl/apb_slave_if_pkg.sv
// Shared state type, counter width and parameter-derivation helpers for the APB slave front-end.
// Latency: none (types and elaboration-time functions only).
// Backpressure: none.
package apb_slave_pkg;

   // Wait-state counter width; it holds 0..15 wait cycles.
   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Number of low address bits that select a byte within one data word.
   function automatic int calc_align(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Register index width; a one-register bank still gets a 1-bit index.
   function automatic int calc_idx_w(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/apb_slave_if_addr_decode.sv
// Decodes the latched APB byte address into a register index plus misalign/range/read-only error flags.
// Latency: purely combinational.
// Backpressure: none; it is a pure function of the latched request.
module apb_addr_decode
   import apb_slave_pkg::*;
#(
   parameter int                  ADDR_W   = 12,
   parameter int                  DATA_W   = 32,
   parameter int                  NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic [ADDR_W-1:0]                   addr,
   input  logic                                write,
   output logic [calc_idx_w(NUM_REGS)-1:0]     idx,
   output logic                                misalign,
   output logic                                range_err,
   output logic                                ro_err
);

   localparam int          ALIGN = calc_align(DATA_W);
   localparam int          IDX_W = calc_idx_w(NUM_REGS);
   localparam logic [63:0] LIMIT = 64'(NUM_REGS) * 64'(DATA_W / 8);

   assign idx = addr[ALIGN +: IDX_W];

   // Byte-wide buses have no sub-word address bits, so they can never be misaligned.
   generate
      if (ALIGN > 0) begin : g_align
         assign misalign = |addr[ALIGN-1:0];
      end else begin : g_no_align
         assign misalign = 1'b0;
      end
   endgenerate

   assign range_err = (64'(addr) >= LIMIT);

   // Read-only lookup; indices past NUM_REGS-1 never match, and those are range errors anyway.
   always_comb begin
      ro_err = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (write && (idx == IDX_W'(i))) begin
            ro_err = RO_MASK[i];
         end
      end
   end

endmodule

// File: rtl/apb_slave_if.sv
// APB4 slave front-end: wait states, byte strobes, error response and an indexed register-bank port.
// Latency: setup + (1 + WAIT_CYCLES) access cycles; the bank is written on the edge ending the pready cycle.
// Backpressure: pready is held low for WAIT_CYCLES access cycles; a low penable freezes the wait counter.
module apb_slave_if
   import apb_slave_pkg::*;
#(
   parameter int                  ADDR_W      = 12,
   parameter int                  DATA_W      = 32,
   parameter int                  NUM_REGS    = 8,
   parameter int                  WAIT_CYCLES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
   input  logic                            tim_psel,
   input  logic                            tim_penable,
   input  logic                            tim_pwrite,
   input  logic [ADDR_W-1:0]               tim_paddr,
   input  logic [DATA_W-1:0]               tim_pwdata,
   input  logic [DATA_W/8-1:0]             tim_pstrb,
   output logic [DATA_W-1:0]               tim_prdata,
   output logic                            tim_pready,
   output logic                            tim_pslverr,
   output logic [calc_idx_w(NUM_REGS)-1:0] reg_idx,
   output logic                            reg_wr_en,
   output logic                            reg_rd_en,
   output logic [DATA_W-1:0]               reg_wdata,
   output logic [DATA_W/8-1:0]             reg_wstrb,
   input  logic [DATA_W-1:0]               reg_rdata
);

   localparam int               STRB_W  = DATA_W / 8;
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   apb_state_e        state;
   apb_state_e        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic              setup;
   logic              pready;
   logic              misalign;
   logic              range_err;
   logic              ro_err;
   logic              err;

   assign setup = tim_psel & ~tim_penable;

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and pready; completion and abort both return to IDLE so every transfer needs a fresh setup.
   always_comb begin
      state_nxt = state;
      pready    = 1'b0;
      case (state)
         IDLE: begin
            if (setup) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            pready = tim_psel & tim_penable & (cnt == '0);
            if (!tim_psel || pready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture the request at the setup edge; count wait states down only while penable is high.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (state == IDLE && setup) begin
         cnt     <= WAIT_LD;
         addr_q  <= tim_paddr;
         write_q <= tim_pwrite;
         wdata_q <= tim_pwdata;
         strb_q  <= tim_pstrb;
      end else if (state == ACCESS && tim_penable && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   apb_addr_decode #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RO_MASK  (RO_MASK)
   ) u_decode (
      .addr      (addr_q),
      .write     (write_q),
      .idx       (reg_idx),
      .misalign  (misalign),
      .range_err (range_err),
      .ro_err    (ro_err)
   );

   assign err = misalign | range_err | ro_err;

   // Errored transfers still complete on the bus but never reach the register bank.
   assign tim_pready  = pready;
   assign tim_pslverr = pready & err;
   assign reg_wr_en   = pready & write_q & ~err;
   assign reg_rd_en   = pready & ~write_q & ~err;
   assign tim_prdata  = reg_rd_en ? reg_rdata : '0;

   // Bank-side data follows the latches continuously; strobes are meaningless on reads and are zeroed.
   assign reg_wdata = wdata_q;
   assign reg_wstrb = write_q ? strb_q : '0;

endmodule

// File: tb/tb_apb_slave_if.sv
// Directed bench for apb_slave_if: one zero-wait and one three-wait instance behind a shared APB driver.
// Latency: checks pready placement cycle by cycle against hand-computed wait counts.
// Backpressure: covers wait states, penable freeze, abort and mid-transfer reset.
module tb_apb_slave_if;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        sel;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] reg_rdata;

   logic        psel_0, psel_3;
   logic [31:0] prdata_0, prdata_3, wdata_0, wdata_3;
   logic        pready_0, pready_3, pslverr_0, pslverr_3;
   logic        wr_en_0, wr_en_3, rd_en_0, rd_en_3;
   logic [2:0]  idx_0, idx_3;
   logic [3:0]  wstrb_0, wstrb_3;

   logic [31:0] prdata, rwdata;
   logic        pready, pslverr, wr_en, rd_en;
   logic [2:0]  ridx;
   logic [3:0]  rwstrb;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 sys_clk = ~sys_clk;

   assign psel_0 = psel & ~sel;
   assign psel_3 = psel & sel;

   assign prdata  = sel ? prdata_3  : prdata_0;
   assign rwdata  = sel ? wdata_3   : wdata_0;
   assign pready  = sel ? pready_3  : pready_0;
   assign pslverr = sel ? pslverr_3 : pslverr_0;
   assign wr_en   = sel ? wr_en_3   : wr_en_0;
   assign rd_en   = sel ? rd_en_3   : rd_en_0;
   assign ridx    = sel ? idx_3     : idx_0;
   assign rwstrb  = sel ? wstrb_3   : wstrb_0;

   apb_slave_if #(
      .ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h40)
   ) u_dut_w0 (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .tim_psel    (psel_0),
      .tim_penable (penable),
      .tim_pwrite  (pwrite),
      .tim_paddr   (paddr),
      .tim_pwdata  (pwdata),
      .tim_pstrb   (pstrb),
      .tim_prdata  (prdata_0),
      .tim_pready  (pready_0),
      .tim_pslverr (pslverr_0),
      .reg_idx     (idx_0),
      .reg_wr_en   (wr_en_0),
      .reg_rd_en   (rd_en_0),
      .reg_wdata   (wdata_0),
      .reg_wstrb   (wstrb_0),
      .reg_rdata   (reg_rdata)
   );

   apb_slave_if #(
      .ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h40)
   ) u_dut_w3 (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .tim_psel    (psel_3),
      .tim_penable (penable),
      .tim_pwrite  (pwrite),
      .tim_paddr   (paddr),
      .tim_pwdata  (pwdata),
      .tim_pstrb   (pstrb),
      .tim_prdata  (prdata_3),
      .tim_pready  (pready_3),
      .tim_pslverr (pslverr_3),
      .reg_idx     (idx_3),
      .reg_wr_en   (wr_en_3),
      .reg_rd_en   (rd_en_3),
      .reg_wdata   (wdata_3),
      .reg_wstrb   (wstrb_3),
      .reg_rdata   (reg_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // ctl nibble is {pready, pslverr, reg_wr_en, reg_rd_en}.
   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, 32'({pready, pslverr, wr_en, rd_en}), 32'h0);
      chk({tag, "_prdata"}, prdata, 32'h0);
   endtask

   task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input int waits,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [2:0] exp_idx, input logic [3:0] exp_wstrb);
      logic [3:0] exp_ctl;
      exp_ctl = {1'b1, exp_err, wr & ~exp_err, ~wr & ~exp_err};
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
      @(negedge sys_clk);
      chk_quiet({tag, "_setup"});
      for (int k = 0; k <= waits; k++) begin
         @(posedge sys_clk); #1;
         penable = 1'b1;
         @(negedge sys_clk);
         if (k < waits) begin
            chk_quiet({tag, "_wait"});
         end else begin
            chk({tag, "_ctl"}, 32'({pready, pslverr, wr_en, rd_en}), 32'(exp_ctl));
            chk({tag, "_prdata"}, prdata, exp_rd);
            chk({tag, "_idx"}, 32'(ridx), 32'(exp_idx));
            chk({tag, "_wstrb"}, 32'(rwstrb), 32'(exp_wstrb));
            chk({tag, "_wdata"}, rwdata, wd);
         end
      end
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
      @(negedge sys_clk);
      chk_quiet({tag, "_after"});
   endtask

   initial begin
      sys_rst_n = 1'b0;
      sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0; reg_rdata = 32'h0;

      // reset values on both instances
      @(negedge sys_clk);
      chk_quiet("rst0");
      chk("rst0_idx", 32'(ridx), 32'h0);
      chk("rst0_wdata", rwdata, 32'h0);
      chk("rst0_wstrb", 32'(rwstrb), 32'h0);
      sel = 1'b1; #1;
      chk_quiet("rst3");
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1; sel = 1'b0;

      // zero-wait instance: good, error and strobe cases
      xfer("wr_w0",     1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 3'd1, 4'hF);
      xfer("mis_wr",    1'b1, 12'h006, 32'h01020304, 4'hF, 0, 1'b1, 32'h0, 3'd1, 4'hF);
      reg_rdata = 32'hA5A5A5A5;
      xfer("oor_rd",    1'b0, 12'h020, 32'h0,        4'h0, 0, 1'b1, 32'h0, 3'd0, 4'h0);
      xfer("ro_wr",     1'b1, 12'h018, 32'hFFFF0000, 4'hF, 0, 1'b1, 32'h0, 3'd6, 4'hF);
      xfer("part_wr",   1'b1, 12'h000, 32'h0000BEEF, 4'h3, 0, 1'b0, 32'h0, 3'd0, 4'h3);
      xfer("zero_strb", 1'b1, 12'h014, 32'h77777777, 4'h0, 0, 1'b0, 32'h0, 3'd5, 4'h0);
      reg_rdata = 32'hCAFEF00D;
      xfer("rd_stray",  1'b0, 12'h01C, 32'h0,        4'hF, 0, 1'b0, 32'hCAFEF00D, 3'd7, 4'h0);

      // three-wait instance: read latency
      sel = 1'b1;
      reg_rdata = 32'h12345678;
      xfer("rd_w3",     1'b0, 12'h008, 32'h0,        4'h0, 3, 1'b0, 32'h12345678, 3'd2, 4'h0);

      // abort: psel dropped in the second wait cycle
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h99999999; pstrb = 4'hF;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      @(negedge sys_clk);
      chk_quiet("abort_w1");
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge sys_clk);
      chk_quiet("abort_w2");
      repeat (3) begin
         @(posedge sys_clk); #1;
         @(negedge sys_clk);
         chk_quiet("abort_idle");
      end
      xfer("post_abort", 1'b1, 12'h00C, 32'h11223344, 4'hF, 3, 1'b0, 32'h0, 3'd3, 4'hF);

      // penable low for one wait cycle freezes the counter: pready moves from access cycle 4 to 5
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0F0F0F0F; pstrb = 4'hC;
      @(negedge sys_clk);
      chk_quiet("frz_setup");
      for (int k = 1; k <= 5; k++) begin
         @(posedge sys_clk); #1;
         penable = (k != 2);
         @(negedge sys_clk);
         if (k < 5) begin
            chk_quiet("frz_wait");
         end else begin
            chk("frz_ctl", 32'({pready, pslverr, wr_en, rd_en}), 32'hA);
            chk("frz_idx", 32'(ridx), 32'd4);
            chk("frz_wstrb", 32'(rwstrb), 32'hC);
         end
      end
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
      @(negedge sys_clk);
      chk_quiet("frz_after");

      // asynchronous reset in the middle of a wait
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      @(negedge sys_clk);
      chk("rstw_idx", 32'(ridx), 32'd1);
      chk("rstw_wdata", rwdata, 32'h55AA55AA);
      chk("rstw_wstrb", 32'(rwstrb), 32'hF);
      @(posedge sys_clk); #2;
      sys_rst_n = 1'b0;
      #1;
      chk_quiet("rst_mid");
      chk("rst_mid_idx", 32'(ridx), 32'h0);
      chk("rst_mid_wdata", rwdata, 32'h0);
      chk("rst_mid_wstrb", 32'(rwstrb), 32'h0);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      xfer("post_rst", 1'b0, 12'h008, 32'h0, 4'h0, 3, 1'b0, 32'h12345678, 3'd2, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
